fmem_fetch_ctrl: RTL and testbench

//  Sequences reads of the filter-coefficient ROM (fmem) for one convolution window.
//  - Each start request triggers one pass: M words (taps 0..M-1) read in order.
//  - Words are streamed to the MAC datapath on a valid/ready interface.
//  - A 4-entry output buffer absorbs the ROM's 1-cycle registered latency, so backpressure never loses a word.

---
 rtl/fmem_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_fmem_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmem_fetch_ctrl.sv
`default_nettype none
// fmem_fetch_ctrl: streams one pass of M filter coefficients from a registered ROM into a 4-deep buffer.
// Optional feature macro FMEM_AUTO_RESTART_EN: a start while busy queues one back-to-back pass.
module fmem_fetch_ctrl #(
  parameter int M  = 13,
  parameter int T  = 20,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] rom_addr,
  input  logic [T-1:0]  rom_data,
  output logic [T-1:0]  m_data,
  output logic [AW-1:0] m_tap,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          done
);

  localparam logic [AW-1:0] LAST_TAP = AW'(M - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nx;

  logic [AW-1:0] addr_nx;
  logic          issue, room, pop, push;
  logic          pend, pend_nx;

  // Two-stage read pipeline: address accepted by ROM, then ROM word captured.
  logic          p1_v, p2_v;
  logic [AW-1:0] p1_tap, p2_tap;
  logic [T-1:0]  p2_data;

  logic [T-1:0]  buf_data [4];
  logic [AW-1:0] buf_tap  [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;

  assign m_valid = (count != 3'd0);
  assign pop     = m_valid & m_ready;
  assign push    = p2_v;
  assign busy    = (state != IDLE);
  assign m_data  = m_valid ? buf_data[rd_ptr] : '0;
  assign m_tap   = m_valid ? buf_tap[rd_ptr] : '0;
  assign m_last  = m_valid && (buf_tap[rd_ptr] == LAST_TAP);

  // Every in-flight read is guaranteed a buffer slot when it lands.
  assign room = ({3'b0, p1_v} + {3'b0, p2_v} + {1'b0, count} - {3'b0, pop}) < 4'd4;

  always_comb begin
    state_nx = state;
    addr_nx  = rom_addr;
    issue    = 1'b0;
    pend_nx  = pend;
`ifdef FMEM_AUTO_RESTART_EN
    if (start && state != IDLE) pend_nx = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (start || pend) begin
          state_nx = FETCH;
          addr_nx  = '0;
          pend_nx  = 1'b0;
        end
      end
      FETCH: begin
        if (room) begin
          issue = 1'b1;
          if (rom_addr == LAST_TAP) begin
            if (pend) begin
              addr_nx = '0;
              pend_nx = 1'b0;
            end else begin
              state_nx = DRAIN;
            end
          end else begin
            addr_nx = rom_addr + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (pend) begin
          state_nx = FETCH;
          addr_nx  = '0;
          pend_nx  = 1'b0;
        end else if (pop && m_last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      pend     <= 1'b0;
      p1_v     <= 1'b0;
      p2_v     <= 1'b0;
      p1_tap   <= '0;
      p2_tap   <= '0;
      p2_data  <= '0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      rom_addr <= addr_nx;
      pend     <= pend_nx;
      p1_v     <= issue;
      p1_tap   <= rom_addr;
      p2_v     <= p1_v;
      p2_tap   <= p1_tap;
      p2_data  <= rom_data;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count    <= count + {2'b0, push} - {2'b0, pop};
      done     <= pop && m_last;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= p2_data;
      buf_tap[wr_ptr]  <= p2_tap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fmem_fetch_ctrl.sv
`default_nettype none
// tb_fmem_fetch_ctrl: randomized and directed checks against a queue-based model of expected taps.
module tb_fmem_fetch_ctrl;
  localparam int M = 13;

  logic        clk = 1'b0;
  logic        reset_n, start, m_ready;
  logic        busy, m_last, m_valid, done;
  logic [3:0]  rom_addr, m_tap;
  logic [19:0] rom_data, m_data;

  int n_tests = 0;
  int n_fail  = 0;

  fmem_fetch_ctrl #(.M(M), .T(20), .AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .m_data(m_data), .m_tap(m_tap), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .done(done)
  );

  always #5 clk = ~clk;

  // Registered ROM: word k = 100 + k.
  always @(posedge clk) rom_data <= 20'(100 + int'(rom_addr));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: queue of taps still owed to the consumer, in order.
  int          exp_q[$];
  int          hs_cnt = 0;
  int          done_cnt = 0;
  bit          exp_done = 0;
  bit          hold = 0;
  bit          mon_en = 0;
  logic [19:0] hold_d;
  logic [3:0]  hold_t;

  always @(negedge clk) begin
    if (mon_en) begin
      int t;
      check("done_pulse", done, exp_done);
      if (hold) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, hold_d);
        check("stall_tap", m_tap, hold_t);
      end
      if (done) done_cnt++;
      exp_done = 0;
      hold = 0;
      if (reset_n && m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else begin
          t = exp_q.pop_front();
          check("tap", m_tap, t);
          check("data", m_data, 100 + t);
          check("last", m_last, t == M - 1);
          exp_done = (t == M - 1);
        end
      end else if (reset_n && m_valid) begin
        hold = 1;
        hold_d = m_data;
        hold_t = m_tap;
      end
    end
  end

  task automatic push_pass();
    for (int i = 0; i < M; i++) exp_q.push_back(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: hold m_ready, 1: toggle each cycle, 2: random
  task automatic wait_done(input int budget, input int mode);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (mode == 1) m_ready = ~m_ready;
      else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
    end
    if (n >= budget) check("timeout", 0, 1);
    check("busy_in_done", busy, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, rom_addr, 0);
    check({tag, "_tap"}, m_tap, 0);
    check({tag, "_data"}, m_data, 0);
  endtask

  initial begin
    int first_v, done_n, base, gaps, dbase, passes;
    bit seen;

    // 1: reset with start held high
    reset_n = 1'b0; start = 1'b1; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1; start = 1'b0;
    mon_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", busy, 0);
    check("idle_no_valid", m_valid, 0);

    // 2: latency and full throughput
    m_ready = 1'b1;
    push_pass();
    start = 1'b1;
    first_v = 0; done_n = 0;
    for (int n = 1; n <= 60 && done_n == 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 1'b0;
        check("busy_after_start", busy, 1);
      end
      if (m_valid && first_v == 0) first_v = n;
      if (done) done_n = n;
    end
    check("first_valid_edge", first_v, 4);
    check("done_edge", done_n, 4 + M);
    check("busy_in_done", busy, 0);
    @(posedge clk); #1;

    // 3: backpressure fills the buffer and stalls issue
    m_ready = 1'b0;
    push_pass();
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    check("stall_addr", rom_addr, 4);
    check("stall_valid_hi", m_valid, 1);
    check("stall_head", m_data, 100);
    m_ready = 1'b1;
    wait_done(100, 0);

    // 4: m_ready toggling
    @(posedge clk); #1;
    m_ready = 1'b1;
    push_pass();
    pulse_start();
    wait_done(100, 1);

    // 5: reset after the 5th handshake aborts, next pass restarts at tap 0
    @(posedge clk); #1;
    m_ready = 1'b1;
    push_pass();
    base = hs_cnt;
    pulse_start();
    for (int n = 0; n < 50 && hs_cnt < base + 5; n++) begin
      @(posedge clk); #1;
    end
    check("five_handshakes", hs_cnt - base, 5);
    reset_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check_zero("abort");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_stray_valid", m_valid, 0);
    push_pass();
    pulse_start();
    wait_done(100, 0);

    // 6: start while busy
    @(posedge clk); #1;
    m_ready = 1'b1;
`ifdef FMEM_AUTO_RESTART_EN
    passes = 2;
`else
    passes = 1;
`endif
    for (int p = 0; p < passes; p++) push_pass();
    base = hs_cnt; dbase = done_cnt; gaps = 0; seen = 0;
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    pulse_start();
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (m_valid) seen = 1;
      if (seen && exp_q.size() > 0 && !m_valid) gaps++;
    end
    check("restart_words", hs_cnt - base, M * passes);
    check("restart_dones", done_cnt - dbase, passes);
    check("restart_gaps", gaps, 0);
    check("restart_queue", exp_q.size(), 0);

    // Randomized backpressure passes
    for (int p = 0; p < 4; p++) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(0, 1));
      push_pass();
      pulse_start();
      wait_done(300, 2);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
